mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Parametrised sequencer for the chunked shift-add multiplier datapath. Splits each operand
//  into NCHUNK chunks and walks all NCHUNK*NCHUNK partial products, driving the chunk
//  selects, shift amount, load/accumulate select and register enable each cycle.
//  Adds an internal step counter, a start/done handshake and abort handling.
// PARAMETERS
//  NCHUNK  2  chunks per operand (>=2); steps per multiply NSTEP = NCHUNK*NCHUNK
//  localparam SEL_W = $clog2(NCHUNK), SH_W = $clog2(2*NCHUNK-1), STP_W = $clog2(NSTEP)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request a multiply; sampled in IDLE only
//  abort        in   1      cancel an in-flight multiply; sampled in RUN only
//  stall        in   1      freeze sequencing (present only with MSEQ_STALL_EN)
//  sela         out  SEL_W  operand-A chunk index for the current step
//  selb         out  SEL_W  operand-B chunk index for the current step
//  sel_shifter  out  SH_W   left shift of the partial product, in chunks (= sela+selb)
//  data_sel     out  1      1 = load accumulator with product, 0 = accumulate
//  clk_en       out  1      datapath accumulator register enable
//  done_flag    out  1      one-cycle pulse: result valid in accumulator
//  err          out  1      one-cycle pulse: multiply aborted, accumulator invalid
//  locked       out  1      1 whenever state != IDLE
//  state        out  2      current state: IDLE=0, RUN=1, FINISH=2, ERROR=3
// BEHAVIOUR
//  - Moore machine: outputs decoded combinationally from registered state + step counter.
//  - Reset: state=IDLE, step=0; outputs: sela=selb=NCHUNK-1, sel_shifter=2*NCHUNK-2,
//    data_sel=1, clk_en=1, done_flag=0, err=0, locked=0.
//  - IDLE: outputs as reset. start=1 -> RUN with step=0 next cycle; abort ignored.
//  - RUN: step k gives sela=(NCHUNK-1)-k/NCHUNK, selb=(NCHUNK-1)-k%NCHUNK,
//    sel_shifter=sela+selb, data_sel=(k==0), clk_en=1. Step increments every cycle;
//    at k=NSTEP-1 -> FINISH. abort=1 in any RUN cycle -> ERROR (step not advanced).
//  - FINISH (1 cycle): done_flag=1, data_sel=1, clk_en=0, sela=selb=0, sel_shifter=0;
//    -> IDLE unconditionally. start/abort ignored.
//  - ERROR (1 cycle): err=1, clk_en=0, data_sel=1, sela=selb=0, sel_shifter=0; -> IDLE.
//  - Latency: start sampled at edge t -> first step at t+1 -> done_flag high in cycle
//    t+NSTEP+1. Next start accepted in the IDLE cycle after FINISH (no back-to-back).
//  - start held high: a new multiply begins each time IDLE is re-entered.
//  - Step counter resets to 0 on entry to IDLE; never wraps inside RUN.
//  - Illegal state encodings cannot occur; default decode = IDLE, next state = IDLE.
//  - rst asserted mid-operation: immediate return to IDLE/reset outputs, no done/err pulse.
// CONFIGURATION
//  MSEQ_STALL_EN defined: stall port exists. In RUN, stall=1 holds step and state,
//    forces clk_en=0, other outputs hold. abort has priority over stall. stall ignored
//    outside RUN. Latency extends by one cycle per stalled RUN cycle.
//  MSEQ_STALL_EN undefined: no stall port; RUN advances every cycle.
// TESTING
//  1 Reset: rst=1 mid-RUN -> state=0, locked=0, sela=selb=1, sel_shifter=2, data_sel=1.
//  2 NCHUNK=2, start pulse -> 4 RUN cycles (sela,selb,sh)=(1,1,2),(1,0,1),(0,1,1),(0,0,0),
//    data_sel=1,0,0,0; done_flag pulse at cycle 5; then IDLE.
//  3 NCHUNK=3 -> 9 RUN steps, sh sequence 4,3,2,3,2,1,2,1,0; done at cycle 10.
//  4 abort at RUN step 2 -> ERROR 1 cycle (err=1, clk_en=0), IDLE, no done_flag.
//  5 start held high 20 cycles, NCHUNK=2 -> done_flag every 6 cycles; start in FINISH ignored.
//  6 MSEQ_STALL_EN: stall=1 for 3 cycles at step 1 -> clk_en=0, step held,
//    done_flag at cycle 8; stall+abort same cycle -> ERROR.

Source files
------------

// File: rtl/mult_seq_if.sv
// Handshake and datapath-control bundle for the chunked shift-add multiplier sequencer.
// The master side issues start/abort (and stall when MSEQ_STALL_EN is defined).
// The slave side is the sequencer, which drives the chunk selects, shift amount,
// accumulator controls and status.
//
// Handshake: start is a level request that is sampled only while state==IDLE.
// done_flag and err are single-cycle pulses, and exactly one of them follows each
// accepted start. abort is sampled only while state==RUN. locked is high from the
// first RUN cycle until the sequencer is back in IDLE.
interface mult_seq_if #(
    parameter int NCHUNK = 2
);
    localparam int SEL_W = $clog2(NCHUNK);
    localparam int SH_W  = $clog2(2*NCHUNK-1);

    logic             start;
    logic             abort;
`ifdef MSEQ_STALL_EN
    logic             stall;
`endif
    logic [SEL_W-1:0] sela;
    logic [SEL_W-1:0] selb;
    logic [SH_W-1:0]  sel_shifter;
    logic             data_sel;
    logic             clk_en;
    logic             done_flag;
    logic             err;
    logic             locked;
    logic [1:0]       state;

    modport master (
`ifdef MSEQ_STALL_EN
        output stall,
`endif
        output start, abort,
        input  sela, selb, sel_shifter, data_sel, clk_en, done_flag, err, locked, state
    );

    modport slave (
`ifdef MSEQ_STALL_EN
        input  stall,
`endif
        input  start, abort,
        output sela, selb, sel_shifter, data_sel, clk_en, done_flag, err, locked, state
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the chunked shift-add multiplier. It walks all NCHUNK*NCHUNK
// partial products, starting with the most significant chunk pair, and drives the
// chunk selects, shift amount, load/accumulate select and accumulator enable.
// Optional feature macro: MSEQ_STALL_EN adds a stall input that freezes RUN.
// All outputs are held in registers. The next values are decoded from the next
// state and next step, so the output timing matches a Moore decode of state+step.
// The one exception is clk_en under stall: it is masked combinationally, because
// a stalled cycle must not write the accumulator.
module mult_seq_ctrl #(
    parameter int NCHUNK = 2
) (
    input  logic     clk,
    input  logic     rst,
    mult_seq_if.slave bus
);
    localparam int NSTEP = NCHUNK*NCHUNK;
    localparam int SEL_W = $clog2(NCHUNK);
    localparam int SH_W  = $clog2(2*NCHUNK-1);
    localparam int STP_W = $clog2(NSTEP);
    localparam logic [STP_W-1:0] LAST_STEP = STP_W'(NSTEP-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [STP_W-1:0] step_q, step_d;

    logic [SEL_W-1:0] sela_q, sela_d;
    logic [SEL_W-1:0] selb_q, selb_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic             data_sel_q, data_sel_d;
    logic             clk_en_q, clk_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             locked_q;
    logic             stall_run;

`ifdef MSEQ_STALL_EN
    // A stall only has an effect while a multiply is in flight.
    assign stall_run = bus.stall && (state_q == S_RUN);
`else
    assign stall_run = 1'b0;
`endif

    // Next state and step. Abort takes priority over stall. The step is cleared on every return to IDLE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                step_d = '0;
                if (bus.start) state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_ERROR;
                end else if (stall_run) begin
                    state_d = S_RUN;
                end else if (step_q == LAST_STEP) begin
                    state_d = S_FINISH;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
            S_ERROR: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Output decode for the upcoming state/step. Step k selects A chunk (N-1)-k/N and B chunk (N-1)-k%N.
    always_comb begin
        sela_d     = SEL_W'(NCHUNK-1);
        selb_d     = SEL_W'(NCHUNK-1);
        sh_d       = SH_W'(2*NCHUNK-2);
        data_sel_d = 1'b1;
        clk_en_d   = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_d)
            S_RUN: begin
                sela_d     = SEL_W'(NCHUNK-1 - int'(step_d) / NCHUNK);
                selb_d     = SEL_W'(NCHUNK-1 - int'(step_d) % NCHUNK);
                sh_d       = SH_W'(int'(sela_d) + int'(selb_d));
                data_sel_d = (step_d == '0);
            end
            S_FINISH: begin
                sela_d   = '0;
                selb_d   = '0;
                sh_d     = '0;
                clk_en_d = 1'b0;
                done_d   = 1'b1;
            end
            S_ERROR: begin
                sela_d   = '0;
                selb_d   = '0;
                sh_d     = '0;
                clk_en_d = 1'b0;
                err_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // State, step counter and registered outputs. Reset returns directly to IDLE values without any pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            sela_q     <= SEL_W'(NCHUNK-1);
            selb_q     <= SEL_W'(NCHUNK-1);
            sh_q       <= SH_W'(2*NCHUNK-2);
            data_sel_q <= 1'b1;
            clk_en_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            sela_q     <= sela_d;
            selb_q     <= selb_d;
            sh_q       <= sh_d;
            data_sel_q <= data_sel_d;
            clk_en_q   <= clk_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            locked_q   <= (state_d != S_IDLE);
        end
    end

    assign bus.sela        = sela_q;
    assign bus.selb        = selb_q;
    assign bus.sel_shifter = sh_q;
    assign bus.data_sel    = data_sel_q;
    assign bus.clk_en      = clk_en_q && !stall_run;
    assign bus.done_flag   = done_q;
    assign bus.err         = err_q;
    assign bus.locked      = locked_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: one NCHUNK=2 instance and one NCHUNK=3 instance.
module tb_mult_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mult_seq_if #(.NCHUNK(2)) bus2();
    mult_seq_if #(.NCHUNK(3)) bus3();

    mult_seq_ctrl #(.NCHUNK(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mult_seq_ctrl #(.NCHUNK(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full output check of the NCHUNK=2 instance.
    task automatic chk2(input string tag, input int st, input int sa, input int sb, input int sh,
                        input int ds, input int ce, input int dn, input int er);
        chk({tag, ".state"},  32'(bus2.state),       32'(st));
        chk({tag, ".sela"},   32'(bus2.sela),        32'(sa));
        chk({tag, ".selb"},   32'(bus2.selb),        32'(sb));
        chk({tag, ".sh"},     32'(bus2.sel_shifter), 32'(sh));
        chk({tag, ".dsel"},   32'(bus2.data_sel),    32'(ds));
        chk({tag, ".clk_en"}, 32'(bus2.clk_en),      32'(ce));
        chk({tag, ".done"},   32'(bus2.done_flag),   32'(dn));
        chk({tag, ".err"},    32'(bus2.err),         32'(er));
        chk({tag, ".locked"}, 32'(bus2.locked),      32'(st != 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int sa2[4];
        int sb2[4];
        int sh2[4];
        int sa3[9];
        int sb3[9];
        int sh3[9];
        int ndone;
        int exp_st;
        sa2 = '{1, 1, 0, 0};
        sb2 = '{1, 0, 1, 0};
        sh2 = '{2, 1, 1, 0};
        sa3 = '{2, 2, 2, 1, 1, 1, 0, 0, 0};
        sb3 = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
        sh3 = '{4, 3, 2, 3, 2, 1, 2, 1, 0};

        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
`ifdef MSEQ_STALL_EN
        bus2.stall = 1'b0;
        bus3.stall = 1'b0;
`endif
        rst = 1'b1;
        #1;
        chk2("reset", 0, 1, 1, 2, 1, 1, 0, 0);
        chk("reset3.sela", 32'(bus3.sela), 32'd2);
        chk("reset3.sh",   32'(bus3.sel_shifter), 32'd4);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk2("idle", 0, 1, 1, 2, 1, 1, 0, 0);

        // NCHUNK=2 multiply
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk2("n2.step0", 1, sa2[0], sb2[0], sh2[0], 1, 1, 0, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk2($sformatf("n2.step%0d", k), 1, sa2[k], sb2[k], sh2[k], 0, 1, 0, 0);
        end
        tick();
        chk2("n2.finish", 2, 0, 0, 0, 1, 0, 1, 0);
        tick();
        chk2("n2.idle", 0, 1, 1, 2, 1, 1, 0, 0);

        // NCHUNK=3 multiply
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            chk($sformatf("n3.s%0d.state", k), 32'(bus3.state), 32'd1);
            chk($sformatf("n3.s%0d.sela", k),  32'(bus3.sela), 32'(sa3[k]));
            chk($sformatf("n3.s%0d.selb", k),  32'(bus3.selb), 32'(sb3[k]));
            chk($sformatf("n3.s%0d.sh", k),    32'(bus3.sel_shifter), 32'(sh3[k]));
            chk($sformatf("n3.s%0d.dsel", k),  32'(bus3.data_sel), 32'(k == 0));
            chk($sformatf("n3.s%0d.done", k),  32'(bus3.done_flag), 32'd0);
        end
        tick();
        chk("n3.fin.done",  32'(bus3.done_flag), 32'd1);
        chk("n3.fin.state", 32'(bus3.state), 32'd2);
        tick();
        chk("n3.idle.state", 32'(bus3.state), 32'd0);
        chk("n3.idle.done",  32'(bus3.done_flag), 32'd0);

        // abort at step 2
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        chk2("ab.step2", 1, 0, 1, 1, 0, 1, 0, 0);
        bus2.abort = 1'b1;
        tick();
        bus2.abort = 1'b0;
        chk2("ab.error", 3, 0, 0, 0, 1, 0, 0, 1);
        tick();
        chk2("ab.idle", 0, 1, 1, 2, 1, 1, 0, 0);
        tick();
        chk("ab.no_done", 32'(bus2.done_flag), 32'd0);

        // reset mid-RUN
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk2("rst_run", 0, 1, 1, 2, 1, 1, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        chk2("rst_run.after", 0, 1, 1, 2, 1, 1, 0, 0);

        // start held high for 20 cycles: period 6, done in cycle 5 of each period
        ndone = 0;
        bus2.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            case (c % 6)
                0:       exp_st = 0;
                5:       exp_st = 2;
                default: exp_st = 1;
            endcase
            chk($sformatf("hold.c%0d.state", c), 32'(bus2.state), 32'(exp_st));
            chk($sformatf("hold.c%0d.done", c),  32'(bus2.done_flag), 32'(c % 6 == 5));
            if (bus2.done_flag === 1'b1) ndone++;
        end
        bus2.start = 1'b0;
        chk("hold.ndone", 32'(ndone), 32'd3);
        repeat (6) tick();
        chk("hold.drain.state", 32'(bus2.state), 32'd0);

`ifdef MSEQ_STALL_EN
        // stall for 3 cycles at step 1
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk2("st.c1", 1, 1, 1, 2, 1, 1, 0, 0);
        tick();
        bus2.stall = 1'b1;
        #1;
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) tick();
            chk2($sformatf("st.c%0d", c), 1, 1, 0, 1, 0, 0, 0, 0);
        end
        tick();
        bus2.stall = 1'b0;
        #1;
        chk2("st.c5", 1, 1, 0, 1, 0, 1, 0, 0);
        tick();
        chk2("st.c6", 1, 0, 1, 1, 0, 1, 0, 0);
        tick();
        chk2("st.c7", 1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk2("st.c8", 2, 0, 0, 0, 1, 0, 1, 0);
        tick();
        chk2("st.idle", 0, 1, 1, 2, 1, 1, 0, 0);
        // stall and abort together: abort wins
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.stall = 1'b1;
        bus2.abort = 1'b1;
        tick();
        bus2.stall = 1'b0;
        bus2.abort = 1'b0;
        chk2("st_ab.error", 3, 0, 0, 0, 1, 0, 0, 1);
        tick();
        chk2("st_ab.idle", 0, 1, 1, 2, 1, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
